pool_sched: RTL and testbench

- Sequencer for the 2x2 stride-2 max-pooling stage: accepts the conv-layer pixel stream under a valid/ready handshake.
- Generates line-buffer write/read addresses and a window-valid strobe per pooled output; the 4-input max unit samples on that strobe.
- Counts pooled outputs and flags end of frame; sits between the conv output and the pooling datapath/FC input.

---
 rtl/pool_sched.sv | 143 ++++++++++++++
 tb/tb_pool_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_sched.sv
// pool_sched: sequencer for the 2x2 stride-2 max-pool stage (line-buffer addressing,
// window strobe, pooled-output count, end of frame). rev 1.0
`default_nettype none

module pool_sched #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CW    = 5,
  parameter int OW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_pix_valid,
  output logic          o_pix_ready,
  output logic          o_wr_en,
  output logic          o_wr_row,
  output logic [CW-1:0] o_wr_col,
  output logic [CW-1:0] o_rd_col0,
  output logic [CW-1:0] o_rd_col1,
  output logic          o_win_valid,
  output logic [CW-1:0] o_out_row,
  output logic [CW-1:0] o_out_col,
  output logic [OW-1:0] o_win_cnt,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic          o_drop_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] C_LAST_ROW = CW'(IMG_H - 1);

  state_t        r_state;
  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_rd_col0;
  logic [CW-1:0] r_rd_col1;
  logic [CW-1:0] r_out_row;
  logic [CW-1:0] r_out_col;
  logic [OW-1:0] r_win_cnt;
  logic          r_win_valid;
  logic          r_frame_done;
  logic          r_drop_err;

  logic w_accept;
  logic w_last_col;
  logic w_last_row;
  logic w_win;

  // Abort outranks an accept, so it withdraws ready in the same cycle.
  assign o_pix_ready = (r_state == S_RUN) && !i_abort;
  assign w_accept    = i_pix_valid && o_pix_ready;
  assign w_last_col  = (r_col == C_LAST_COL);
  assign w_last_row  = (r_row == C_LAST_ROW);
  assign w_win       = w_accept && r_row[0] && r_col[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_rd_col0    <= '0;
      r_rd_col1    <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_win_cnt    <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_drop_err   <= 1'b0;
    end else begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (i_pix_valid && (r_state != S_RUN)) begin
        r_drop_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_RUN;
            r_row      <= '0;
            r_col      <= '0;
            r_win_cnt  <= '0;
            r_drop_err <= 1'b0;
          end
        end
        S_RUN: begin
          if (i_abort) begin
            r_state <= S_IDLE;
          end else if (w_accept) begin
            if (w_win) begin
              r_win_valid <= 1'b1;
              r_rd_col0   <= r_col - CW'(1);
              r_rd_col1   <= r_col;
              r_out_row   <= r_row >> 1;
              r_out_col   <= r_col >> 1;
              r_win_cnt   <= r_win_cnt + OW'(1);
            end
            if (w_last_col) begin
              r_col <= '0;
              // Row wraps on the final pixel so the counter never exceeds IMG_H-1.
              r_row <= w_last_row ? '0 : r_row + CW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
            if (w_last_col && w_last_row) begin
              r_state      <= S_LAST;
              r_frame_done <= 1'b1;
            end
          end
        end
        S_LAST: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_wr_en      = w_accept;
  assign o_wr_row     = r_row[0];
  assign o_wr_col     = r_col;
  assign o_rd_col0    = r_rd_col0;
  assign o_rd_col1    = r_rd_col1;
  assign o_win_valid  = r_win_valid;
  assign o_out_row    = r_out_row;
  assign o_out_col    = r_out_col;
  assign o_win_cnt    = r_win_cnt;
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = r_frame_done;
  assign o_drop_err   = r_drop_err;

endmodule

`default_nettype wire

// File: tb/tb_pool_sched.sv
// tb_pool_sched: table vectors, directed frame sequences and random traffic
// checked against a pixel-index reference model. rev 1.0
`default_nettype none

module tb_pool_sched;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int CW    = 5;
  localparam int OW    = 8;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NWIN  = NPIX / 4;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic          i_abort;
  logic          i_pix_valid;
  logic          o_pix_ready;
  logic          o_wr_en;
  logic          o_wr_row;
  logic [CW-1:0] o_wr_col;
  logic [CW-1:0] o_rd_col0;
  logic [CW-1:0] o_rd_col1;
  logic          o_win_valid;
  logic [CW-1:0] o_out_row;
  logic [CW-1:0] o_out_col;
  logic [OW-1:0] o_win_cnt;
  logic          o_busy;
  logic          o_frame_done;
  logic          o_drop_err;

  pool_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .OW(OW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_pix_valid  (i_pix_valid),
    .o_pix_ready  (o_pix_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_row     (o_wr_row),
    .o_wr_col     (o_wr_col),
    .o_rd_col0    (o_rd_col0),
    .o_rd_col1    (o_rd_col1),
    .o_win_valid  (o_win_valid),
    .o_out_row    (o_out_row),
    .o_out_col    (o_out_col),
    .o_win_cnt    (o_win_cnt),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_drop_err   (o_drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frame progress is a flat pixel index; row/col derived by arithmetic.
  int m_mode = 0;  // 0 idle, 1 streaming, 2 final cycle
  int m_p    = 0;
  int m_cnt  = 0;
  int m_drop = 0;
  int m_win  = 0;
  int m_done = 0;
  int m_rd0  = 0;
  int m_rd1  = 0;
  int m_orow = 0;
  int m_ocol = 0;

  int f_wins, f_dones, f_first_win, f_done_at;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_p = 0; m_cnt = 0; m_drop = 0; m_win = 0; m_done = 0;
    m_rd0 = 0; m_rd1 = 0; m_orow = 0; m_ocol = 0;
  endtask

  task automatic model_step(input bit s, input bit a, input bit v);
    int r, c;
    m_win = 0;
    m_done = 0;
    if (v && m_mode != 1) m_drop = 1;
    case (m_mode)
      0: if (s) begin m_mode = 1; m_p = 0; m_cnt = 0; m_drop = 0; end
      1: begin
        if (a) begin
          m_mode = 0;
        end else if (v) begin
          r = m_p / IMG_W;
          c = m_p % IMG_W;
          if (r % 2 == 1 && c % 2 == 1) begin
            m_win = 1; m_rd0 = c - 1; m_rd1 = c; m_orow = r / 2; m_ocol = c / 2;
            m_cnt++;
          end
          m_p++;
          if (m_p == NPIX) begin m_mode = 2; m_done = 1; end
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  // One clock of stimulus, comparing combinational outputs then registered outputs.
  task automatic cyc(input bit s, input bit a, input bit v);
    int e_ready;
    i_start = s; i_abort = a; i_pix_valid = v;
    #1;
    e_ready = (m_mode == 1 && !a) ? 1 : 0;
    chk("pix_ready", o_pix_ready, e_ready);
    chk("wr_en", o_wr_en, (v && e_ready) ? 1 : 0);
    if (v && e_ready) begin
      chk("wr_row", o_wr_row, (m_p / IMG_W) % 2);
      chk("wr_col", o_wr_col, m_p % IMG_W);
    end
    @(posedge clk);
    model_step(s, a, v);
    #1;
    chk("win_valid", o_win_valid, m_win);
    chk("frame_done", o_frame_done, m_done);
    chk("win_cnt", o_win_cnt, m_cnt);
    chk("busy", o_busy, (m_mode != 0) ? 1 : 0);
    chk("drop_err", o_drop_err, m_drop);
    chk("rd_col0", o_rd_col0, m_rd0);
    chk("rd_col1", o_rd_col1, m_rd1);
    chk("out_row", o_out_row, m_orow);
    chk("out_col", o_out_col, m_ocol);
  endtask

  task automatic async_reset_check();
    i_pix_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pix_ready", o_pix_ready, 0);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_win_valid", o_win_valid, 0);
    chk("rst_win_cnt", o_win_cnt, 0);
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_drop_err", o_drop_err, 0);
    chk("rst_rd_col1", o_rd_col1, 0);
    chk("rst_out_row", o_out_row, 0);
    chk("rst_out_col", o_out_col, 0);
    i_pix_valid = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Start, then stream until the model returns to idle; abort_at<0 disables abort.
  task automatic run_frame(input int bubble_pct, input int abort_at, input bit poke_start);
    int guard;
    bit s, a, v;
    f_wins = 0; f_dones = 0; f_first_win = -1; f_done_at = -1;
    cyc(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (m_mode != 0 && guard < 20000) begin
      v = ($urandom_range(99) >= bubble_pct);
      a = (abort_at >= 0 && m_p == abort_at && m_mode == 1);
      s = poke_start && (m_p == 10 || m_mode == 2);
      cyc(s, a, v);
      if (o_win_valid) begin
        if (f_first_win < 0) f_first_win = guard;
        f_wins++;
      end
      if (o_frame_done) begin
        f_dones++;
        f_done_at = guard;
      end
      guard++;
    end
    chk("frame_timeout", (guard < 20000) ? 1 : 0, 1);
  endtask

  typedef struct {
    bit s, a, v;
    bit e_ready, e_wr, e_busy, e_drop;
  } vec_t;

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl[10];
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_pix_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", o_busy, 0);
    chk("reset_win_cnt", o_win_cnt, 0);
    chk("reset_drop_err", o_drop_err, 0);
    chk("reset_win_valid", o_win_valid, 0);
    rst_n = 1'b1;

    //          s  a  v   ready wr busy drop (drop/busy after the edge)
    tbl[0] = '{0, 0, 0,  0, 0, 0, 0};
    tbl[1] = '{0, 0, 1,  0, 0, 0, 1};  // valid while idle: drop, no write
    tbl[2] = '{0, 0, 0,  0, 0, 0, 1};  // sticky
    tbl[3] = '{1, 0, 0,  0, 0, 1, 0};  // start clears
    tbl[4] = '{0, 0, 1,  1, 1, 1, 0};
    tbl[5] = '{1, 0, 0,  1, 0, 1, 0};  // start while busy ignored
    tbl[6] = '{0, 1, 1,  0, 0, 0, 0};  // abort wins over accept
    tbl[7] = '{0, 0, 1,  0, 0, 0, 1};
    tbl[8] = '{1, 0, 0,  0, 0, 1, 0};
    tbl[9] = '{0, 1, 0,  0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      i_start = tbl[i].s; i_abort = tbl[i].a; i_pix_valid = tbl[i].v;
      #1;
      chk($sformatf("tbl%0d_ready", i), o_pix_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_wr_en", i), o_wr_en, tbl[i].e_wr);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_drop", i), o_drop_err, tbl[i].e_drop);
    end
    async_reset_check();

    // Contiguous frame: first window on pixel 29 (row1,col1), done on pixel 783.
    run_frame(0, -1, 1'b0);
    chk("contig_wins", f_wins, NWIN);
    chk("contig_dones", f_dones, 1);
    chk("contig_first_win_iter", f_first_win, IMG_W + 1);
    chk("contig_done_iter", f_done_at, NPIX - 1);
    chk("contig_win_cnt", o_win_cnt, NWIN);
    cyc(1'b0, 1'b0, 1'b0);
    chk("contig_idle_after", o_busy, 0);

    // Bubbles.
    run_frame(50, -1, 1'b0);
    chk("bubble_wins", f_wins, NWIN);
    chk("bubble_dones", f_dones, 1);
    chk("bubble_win_cnt", o_win_cnt, NWIN);

    // Abort at pixel 300: rows 1,3,5,7,9 complete -> 5*14 windows.
    run_frame(30, 300, 1'b0);
    chk("abort_dones", f_dones, 0);
    chk("abort_win_cnt", o_win_cnt, 70);
    cyc(1'b1, 1'b0, 1'b0);
    chk("abort_restart_clear", o_win_cnt, 0);
    cyc(1'b0, 1'b1, 1'b0);
    run_frame(20, -1, 1'b0);
    chk("after_abort_win_cnt", o_win_cnt, NWIN);
    chk("after_abort_dones", f_dones, 1);

    // start pokes at pixel 10 and in the final cycle.
    run_frame(25, -1, 1'b1);
    chk("poke_dones", f_dones, 1);
    chk("poke_win_cnt", o_win_cnt, NWIN);
    chk("poke_busy_after", o_busy, 0);

    // Asynchronous reset mid-frame at pixel 500.
    cyc(1'b1, 1'b0, 1'b0);
    for (int g = 0; g < 5000 && m_p < 500; g++) cyc(1'b0, 1'b0, 1'($urandom_range(1)));
    chk("pre_reset_p", m_p, 500);
    async_reset_check();
    run_frame(40, -1, 1'b0);
    chk("post_reset_wins", f_wins, NWIN);
    chk("post_reset_win_cnt", o_win_cnt, NWIN);

    // Random traffic with occasional start/abort anywhere.
    for (int k = 0; k < 6000; k++) begin
      cyc(1'($urandom_range(15) == 0), 1'($urandom_range(799) == 0),
          1'($urandom_range(3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
